// File: rtl/rx_deframer.sv
// Receive deframer: parses preamble/length headers from the RS-decoded byte stream,
// buffers admitted payload in a FIFO and serves it on a first-word fall-through val/ack port.
module rx_deframer #(
    parameter int RS_K    = 239,
    parameter int FIFO_AW = 11
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_sof,
    input  logic        i_data_val,
    input  logic [7:0]  i_data,
    output logic        o_ati_val,
    output logic        o_ati_sof,
    output logic        o_ati_eof,
    output logic        o_ati_err,
    output logic [7:0]  o_ati_data,
    input  logic        i_ati_ack,
    output logic [14:0] o_frame_len,
    output logic        o_rate_115200,
    output logic        o_err_hdr,
    output logic        o_err_drop,
    output logic        o_err_abort
);

    localparam int BW    = (RS_K > 1) ? $clog2(RS_K) : 1;
    localparam int DEPTH = 2 ** FIFO_AW;
    localparam logic [BW-1:0] BLK_LAST = BW'(RS_K - 1);

    typedef enum logic [2:0] {
        IDLE,
        LEN0,
        LEN1,
        PAYLOAD,
        DROP,
        PAD
    } state_t;

    state_t        state;
    logic [BW-1:0] blk;
    logic [7:0]    len_lo;
    logic [14:0]   rem;

    logic [9:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW:0]   mem_count;
    logic [FIFO_AW:0]   level;
    logic               sof_pending;

    logic        wr_en;
    logic [9:0]  wr_word;
    logic [9:0]  rd_word;
    logic        load;
    logic [14:0] len_full;
    logic [31:0] free_entries;
    logic        fits;

    // Level counts the output register too, so total storage equals DEPTH.
    assign level    = mem_count + {{FIFO_AW{1'b0}}, o_ati_val};
    assign len_full = {i_data[6:0], len_lo};
    assign rd_word  = mem[rd_ptr];
    assign load     = (mem_count != '0) && (!o_ati_val || i_ati_ack);

    always_comb begin
        free_entries = 32'(DEPTH) - 32'(level);
        fits         = (32'(len_full) + 32'd1) <= free_entries;
    end

    // The abort marker needs no space check: admission reserved len+1 entries.
    always_comb begin
        wr_en   = 1'b0;
        wr_word = '0;
        if (i_data_val) begin
            if (i_sof) begin
                if (state == PAYLOAD && rem != o_frame_len) begin
                    wr_en   = 1'b1;
                    wr_word = 10'h300;
                end
            end else if (state == PAYLOAD) begin
                wr_en   = 1'b1;
                wr_word = {1'b0, (rem == 15'd1), i_data};
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state         <= IDLE;
            blk           <= '0;
            len_lo        <= '0;
            rem           <= '0;
            o_frame_len   <= '0;
            o_rate_115200 <= 1'b0;
            o_err_hdr     <= 1'b0;
            o_err_drop    <= 1'b0;
            o_err_abort   <= 1'b0;
        end else begin
            o_err_hdr   <= 1'b0;
            o_err_drop  <= 1'b0;
            o_err_abort <= 1'b0;
            if (i_data_val) begin
                if (i_sof)
                    blk <= BW'(1);
                else if (blk == BLK_LAST)
                    blk <= '0;
                else
                    blk <= blk + BW'(1);

                if (i_sof) begin
                    if (state != IDLE)
                        o_err_abort <= 1'b1;
                    if (i_data == 8'h55) begin
                        o_rate_115200 <= 1'b1;
                        state         <= LEN0;
                    end else if (i_data == 8'hAA) begin
                        o_rate_115200 <= 1'b0;
                        state         <= LEN0;
                    end else begin
                        o_err_hdr <= 1'b1;
                        state     <= IDLE;
                    end
                end else begin
                    unique case (state)
                        IDLE: ;
                        LEN0: begin
                            len_lo <= i_data;
                            state  <= LEN1;
                        end
                        LEN1: begin
                            if (i_data[7] || len_full == 15'd0) begin
                                o_err_hdr <= 1'b1;
                                state     <= PAD;
                            end else if (!fits) begin
                                o_err_drop <= 1'b1;
                                rem        <= len_full;
                                state      <= DROP;
                            end else begin
                                o_frame_len <= len_full;
                                rem         <= len_full;
                                state       <= PAYLOAD;
                            end
                        end
                        PAYLOAD, DROP: begin
                            rem <= rem - 15'd1;
                            if (rem == 15'd1)
                                state <= (blk == BLK_LAST) ? IDLE : PAD;
                        end
                        PAD: begin
                            if (blk == BLK_LAST)
                                state <= IDLE;
                        end
                        default: state <= IDLE;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (wr_en)
            mem[wr_ptr] <= wr_word;
    end

    // Output register is the fall-through head; it refills whenever it is empty or being taken.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            mem_count   <= '0;
            sof_pending <= 1'b1;
            o_ati_val   <= 1'b0;
            o_ati_sof   <= 1'b0;
            o_ati_eof   <= 1'b0;
            o_ati_err   <= 1'b0;
            o_ati_data  <= '0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + FIFO_AW'(1);

            if (load) begin
                rd_ptr      <= rd_ptr + FIFO_AW'(1);
                o_ati_val   <= 1'b1;
                o_ati_err   <= rd_word[9];
                o_ati_eof   <= rd_word[8];
                o_ati_data  <= rd_word[7:0];
                o_ati_sof   <= sof_pending;
                sof_pending <= rd_word[8];
            end else if (o_ati_val && i_ati_ack) begin
                o_ati_val  <= 1'b0;
                o_ati_sof  <= 1'b0;
                o_ati_eof  <= 1'b0;
                o_ati_err  <= 1'b0;
                o_ati_data <= '0;
            end

            unique case ({wr_en, load})
                2'b10:   mem_count <= mem_count + (FIFO_AW + 1)'(1);
                2'b01:   mem_count <= mem_count - (FIFO_AW + 1)'(1);
                default: ;
            endcase
        end
    end

endmodule
